mem_port_arbiter: RTL and testbench

Arbitrates the single main-memory port between the instruction-fetch side (IF stage / I-cache) and the data side (MEM stage / D-cache) of the RV32IM pipeline. It drives the BUSYWAIT that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers while either requester waits. A two-state-plus-idle FSM provides data-side priority with no instruction starvation, plus a timeout watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter.
//   arb_state_e          : arbiter FSM states (idle, serving data side, serving instruction side)
//   ARB_TIMEOUT_DEFAULT  : default watchdog limit in serve cycles
//   ARB_CNT_W            : width of the watchdog counter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_D = 2'd1,
    ARB_SERVE_I = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
  localparam int unsigned ARB_CNT_W           = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the arbiter, the two requesters and the memory.
//   Instruction side : I_READ, I_ADDRESS -> I_READDATA, I_BUSYWAIT
//   Data side        : D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA -> D_READDATA, D_BUSYWAIT
//   Pipeline         : PIPE_BUSYWAIT (stall for all pipeline registers)
//   Memory           : MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA -> MEM_READDATA, MEM_BUSYWAIT
//   Status           : ERROR (sticky watchdog flag)
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding requesters and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              PIPE_BUSYWAIT;

  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  logic              ERROR;

  modport slave (
    input  I_READ, I_ADDRESS,
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT,
    output D_READDATA, D_BUSYWAIT,
    output PIPE_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output ERROR
  );

  modport master (
    output I_READ, I_ADDRESS,
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT,
    input  D_READDATA, D_BUSYWAIT,
    input  PIPE_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  ERROR
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch and the
// data side. Data requests win in IDLE; when a data transaction completes
// while an instruction read waits, the port goes straight to the instruction
// side so fetch cannot be starved. A watchdog aborts a serve that exceeds
// TIMEOUT cycles and raises a sticky ERROR.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-low reset
//   bus   : mem_port_arbiter_if.slave (requesters, memory, stall and error)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus
);

  // Watchdog fires on the edge that closes the TIMEOUT-th serve cycle.
  localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic                  started_q, started_d;
  logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  error_q, error_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

  logic d_req;
  logic serving;
  logic done;
  logic done_d;
  logic done_i;
  logic timeout;
  logic grant_d;
  logic grant_i;
  logic release_port;

  assign d_req   = bus.D_READ | bus.D_WRITE;
  assign serving = (state_q != ARB_IDLE);
  // Memory must first show it has taken the command (busy seen) before a
  // low MEM_BUSYWAIT can mean completion.
  assign done    = serving && started_q && !bus.MEM_BUSYWAIT;
  assign done_d  = done && (state_q == ARB_SERVE_D);
  assign done_i  = done && (state_q == ARB_SERVE_I);
  assign timeout = serving && !done && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    started_d    = started_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    release_port = 1'b0;

    if (serving) begin
      cnt_d = cnt_q + 1'b1;
      if (bus.MEM_BUSYWAIT) begin
        started_d = 1'b1;
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (d_req) begin
          grant_d = 1'b1;
        end else if (bus.I_READ) begin
          grant_i = 1'b1;
        end
      end
      ARB_SERVE_D: begin
        if (done_d) begin
          if (bus.D_READ) begin
            d_rdata_d = bus.MEM_READDATA;
          end
          // Hand the port straight to a waiting fetch; otherwise go idle.
          if (bus.I_READ) begin
            grant_i = 1'b1;
          end else begin
            release_port = 1'b1;
          end
        end
      end
      ARB_SERVE_I: begin
        if (done_i) begin
          // A fetch flushed mid-serve leaves I_READ low: its data is dropped.
          if (bus.I_READ) begin
            i_rdata_d = bus.MEM_READDATA;
          end
          release_port = 1'b1;
        end
      end
      default: begin
        release_port = 1'b1;
      end
    endcase

    if (timeout) begin
      error_d      = 1'b1;
      release_port = 1'b1;
    end

    if (grant_d) begin
      state_d     = ARB_SERVE_D;
      mem_read_d  = bus.D_READ;
      mem_write_d = bus.D_WRITE;
      mem_addr_d  = bus.D_ADDRESS;
      mem_wdata_d = bus.D_WRITEDATA;
      started_d   = 1'b0;
      cnt_d       = '0;
    end else if (grant_i) begin
      state_d     = ARB_SERVE_I;
      mem_read_d  = 1'b1;
      mem_write_d = 1'b0;
      mem_addr_d  = bus.I_ADDRESS;
      mem_wdata_d = '0;
      started_d   = 1'b0;
      cnt_d       = '0;
    end else if (release_port) begin
      state_d     = ARB_IDLE;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      started_d   = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ARB_IDLE;
      started_q   <= 1'b0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Requester stalls are combinational so they act in the request cycle.
  assign bus.I_BUSYWAIT    = bus.I_READ && !done_i;
  assign bus.D_BUSYWAIT    = d_req && !done_d;
  assign bus.PIPE_BUSYWAIT = bus.I_BUSYWAIT | bus.D_BUSYWAIT;

  // Read data flows through in the completion cycle, then comes from the hold register.
  assign bus.I_READDATA    = done_i ? bus.MEM_READDATA : i_rdata_q;
  assign bus.D_READDATA    = done_d ? bus.MEM_READDATA : d_rdata_q;

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.ERROR         = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural memory with programmable
// latency, transaction-level reference for grant order, completion cycles,
// read data and memory commands; directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ 16'h5A3C};
  endfunction

  // ---------------- behavioural memory ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        mem_log[$];
  logic [31:0] mem_arr [0:255];
  int          mem_lat   = 1;
  bit          mem_stuck = 1'b0;
  int          m_cnt;
  logic        m_cool;
  cmd_t        m_cur;

  // Busy for mem_lat cycles after accepting a command, then one cycle of
  // completion during which the still-present command is ignored.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.MEM_BUSYWAIT <= 1'b0;
      bus.MEM_READDATA <= '0;
      m_cnt            <= 0;
      m_cool           <= 1'b0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= pat(32'(i) << 2);
      mem_arr[16]      <= 32'h0050_0093;
    end else if (mem_stuck) begin
      bus.MEM_BUSYWAIT <= 1'b1;
      m_cnt            <= 1;
    end else if (bus.MEM_BUSYWAIT) begin
      if (m_cnt <= 1) begin
        bus.MEM_BUSYWAIT <= 1'b0;
        m_cool           <= 1'b1;
        if (m_cur.we) mem_arr[m_cur.a[9:2]] <= m_cur.d;
        else          bus.MEM_READDATA      <= mem_arr[m_cur.a[9:2]];
      end
      m_cnt <= m_cnt - 1;
    end else if (m_cool) begin
      m_cool <= 1'b0;
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      bus.MEM_BUSYWAIT <= 1'b1;
      m_cnt            <= mem_lat;
      m_cur            <= '{bus.MEM_WRITE, bus.MEM_ADDRESS, bus.MEM_WRITEDATA};
      mem_log.push_back('{bus.MEM_WRITE, bus.MEM_ADDRESS, bus.MEM_WRITEDATA});
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_arr [logic [31:0]];
  logic [31:0] last_idata = '0;
  logic [31:0] last_ddata = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_arr.exists(a)) return ref_arr[a];
    return pat(a);
  endfunction

  // One transaction starting in IDLE at the current cycle (cycle 0).
  // Data side is granted first; a waiting fetch follows it without an idle
  // cycle. Completion: single side N+2, fetch behind data 2N+4.
  task automatic run_txn(input bit use_i, input bit use_d, input bit dwr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] dwd, input int n);
    int          exp_i, exp_d, got_i, got_d;
    logic [31:0] exp_idata, exp_ddata;
    cmd_t        exp_log[$];
    cmd_t        got_cmd;
    mem_lat   = n;
    exp_d     = use_d ? n + 2 : -1;
    exp_i     = use_i ? (use_d ? 2 * n + 4 : n + 2) : -1;
    exp_ddata = ref_rd(da);
    if (use_d) begin
      exp_log.push_back('{dwr, da, dwd});
      if (dwr) ref_arr[da] = dwd;
    end
    exp_idata = ref_rd(ia);
    if (use_i) exp_log.push_back('{1'b0, ia, 32'h0});

    bus.I_READ      = use_i;
    bus.I_ADDRESS   = ia;
    bus.D_READ      = use_d && !dwr;
    bus.D_WRITE     = use_d && dwr;
    bus.D_ADDRESS   = da;
    bus.D_WRITEDATA = dwd;
    got_i = -1;
    got_d = -1;
    for (int c = 0; c < 4 * n + 20; c++) begin
      @(negedge CLK);
      if (c == 0) check_val("pipe_bw_c0", bus.PIPE_BUSYWAIT, 1);
      if (c == 1) begin
        check_val("mem_read_c1", bus.MEM_READ, use_d ? !dwr : 1'b1);
        check_val("mem_write_c1", bus.MEM_WRITE, use_d && dwr);
        check_val("mem_addr_c1", bus.MEM_ADDRESS, use_d ? da : ia);
      end
      if (use_i && use_d && c == n + 3) begin
        check_val("i_after_d_read", bus.MEM_READ, 1);
        check_val("i_after_d_addr", bus.MEM_ADDRESS, ia);
      end
      if (bus.I_READ && !bus.I_BUSYWAIT && got_i < 0) begin
        got_i = c;
        check_val("i_rdata", bus.I_READDATA, exp_idata);
      end
      if ((bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT && got_d < 0) begin
        got_d = c;
        if (bus.D_READ) check_val("d_rdata", bus.D_READDATA, exp_ddata);
      end
      @(posedge CLK); #1;
      if (got_i == c) bus.I_READ = 1'b0;
      if (got_d == c) begin
        bus.D_READ  = 1'b0;
        bus.D_WRITE = 1'b0;
      end
      if (!(bus.I_READ || bus.D_READ || bus.D_WRITE)) break;
    end
    bus.I_READ  = 1'b0;
    bus.D_READ  = 1'b0;
    bus.D_WRITE = 1'b0;
    if (use_i) check_val("i_done_cycle", 32'(got_i), 32'(exp_i));
    if (use_d) check_val("d_done_cycle", 32'(got_d), 32'(exp_d));
    if (use_i) last_idata = exp_idata;
    if (use_d && !dwr) last_ddata = exp_ddata;

    @(negedge CLK);
    check_val("i_rdata_hold", bus.I_READDATA, last_idata);
    check_val("d_rdata_hold", bus.D_READDATA, last_ddata);
    check_val("log_count", 32'(mem_log.size()), 32'(exp_log.size()));
    while (exp_log.size() > 0 && mem_log.size() > 0) begin
      got_cmd = mem_log.pop_front();
      check_val("cmd_we", got_cmd.we, exp_log[0].we);
      check_val("cmd_addr", got_cmd.a, exp_log[0].a);
      if (exp_log[0].we) check_val("cmd_wdata", got_cmd.d, exp_log[0].d);
      void'(exp_log.pop_front());
    end
    mem_log.delete();
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t flush_cmd;
    ref_arr[32'h40] = 32'h0050_0093;
    RESET           = 1'b0;
    bus.I_READ      = 1'b1;
    bus.I_ADDRESS   = 32'h20;
    bus.D_READ      = 1'b0;
    bus.D_WRITE     = 1'b0;
    bus.D_ADDRESS   = '0;
    bus.D_WRITEDATA = '0;

    // Reset with a fetch pending
    repeat (3) @(negedge CLK);
    check_val("rst_mem_read", bus.MEM_READ, 0);
    check_val("rst_error", bus.ERROR, 0);
    check_val("rst_i_bw", bus.I_BUSYWAIT, 1);
    check_val("rst_d_bw", bus.D_BUSYWAIT, 0);
    check_val("rst_i_rdata", bus.I_READDATA, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    run_txn(1, 0, 0, 32'h20, 32'h0, 32'h0, 2);

    // Fetch only, three busy cycles
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 3);
    // Data write
    run_txn(0, 1, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 2);
    // Simultaneous fetch and data read
    run_txn(1, 1, 0, 32'h44, 32'h200, 32'h0, 2);

    // Fetch flushed in cycle 2 of its serve
    mem_lat       = 3;
    bus.I_READ    = 1'b1;
    bus.I_ADDRESS = 32'h80;
    @(negedge CLK);
    check_val("flush_bw_c0", bus.I_BUSYWAIT, 1);
    repeat (2) begin @(posedge CLK); #1; end
    bus.I_READ = 1'b0;
    @(negedge CLK);
    check_val("flush_bw_dropped", bus.I_BUSYWAIT, 0);
    repeat (4) begin @(posedge CLK); #1; end
    @(negedge CLK);
    check_val("flush_rdata_kept", bus.I_READDATA, last_idata);
    check_val("flush_log_count", 32'(mem_log.size()), 1);
    if (mem_log.size() > 0) begin
      flush_cmd = mem_log.pop_front();
      check_val("flush_cmd_addr", flush_cmd.a, 32'h80);
    end
    @(posedge CLK); #1;
    run_txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 2);

    // Random traffic
    for (int t = 0; t < 30; t++) begin
      int          kind;
      logic [31:0] ra, rd_a;
      kind = $urandom_range(0, 3);
      ra   = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      rd_a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      run_txn(kind != 1 && kind != 2, kind != 0, kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1),
              ra, rd_a, $urandom, $urandom_range(1, 5));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    // Memory stuck busy: watchdog
    mem_stuck = 1'b1;
    @(posedge CLK); #1;
    bus.I_READ    = 1'b1;
    bus.I_ADDRESS = 32'h300;
    for (int c = 0; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 8) begin
        check_val("to_error_before", bus.ERROR, 0);
        check_val("to_read_before", bus.MEM_READ, 1);
      end
      if (c == 9) begin
        check_val("to_error_set", bus.ERROR, 1);
        check_val("to_read_cleared", bus.MEM_READ, 0);
        check_val("to_i_bw", bus.I_BUSYWAIT, 1);
      end
      if (c < 9) begin @(posedge CLK); #1; end
    end
    bus.I_READ = 1'b0;
    mem_stuck  = 1'b0;
    repeat (5) @(negedge CLK);
    check_val("to_error_sticky", bus.ERROR, 1);
    check_val("to_read_idle", bus.MEM_READ, 0);
    RESET = 1'b0;
    #1;
    check_val("to_error_rst", bus.ERROR, 0);
    check_val("to_read_rst", bus.MEM_READ, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
